clk_div_ctrl: RTL

- Programmable integer clock divider with glitch-free ratio change and glitch-free start/stop.
- Upstream stage of the clock inverter wrapper: its registered divided clock clk_o drives the inverter's input, and the inverter's zn_o gives the opposite phase.
- Every output is a flop output, so the divided clock never carries a combinational glitch.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the programmable clock divider
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } clk_div_state_e;

    localparam int MIN_DIV = 2;

    // Ratios 0 and 1 cannot form a two-phase clock, so they run as the minimum ratio
    function automatic logic [31:0] eff_div(input logic [31:0] n);
        return (n < 32'(MIN_DIV)) ? 32'(MIN_DIV) : n;
    endfunction

endpackage

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable integer clock divider with glitch-free ratio change and start/stop
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             busy_o
);

    clk_div_state_e   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ratio;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_ready;
    logic             r_clk;
    logic             r_tick;
    logic             r_busy;

    clk_div_state_e   w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_ne_cur;
    logic [CNT_W-1:0] w_ne_nxt;
    logic [CNT_W-1:0] w_ratio_nxt;
    logic             w_wrap;
    logic             w_accept;
    logic             w_apply;
    logic             w_run_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;

    assign w_ne_cur    = CNT_W'(eff_div(32'(r_ratio)));
    // Wrap only exists while a period is in flight; IDLE holds cnt at 0
    assign w_wrap      = (r_state != IDLE) && (r_cnt == (w_ne_cur - CNT_W'(1)));
    assign w_accept    = div_valid_i && r_ready;
    // A pending ratio lands only on a period boundary, or at once when no period is running
    assign w_apply     = r_pend_vld && ((r_state == IDLE) || w_wrap);
    assign w_ratio_nxt = w_apply ? r_pend : r_ratio;
    assign w_ne_nxt    = CNT_W'(eff_div(32'(w_ratio_nxt)));

    // Next-state, next count and next registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = en_i ? RUN : IDLE;
            end
            RUN, DRAIN: begin
                w_cnt_nxt = w_wrap ? '0 : (r_cnt + CNT_W'(1));
                if (w_wrap) begin
                    w_state_nxt = en_i ? RUN : IDLE;
                end else begin
                    w_state_nxt = en_i ? RUN : DRAIN;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
        w_run_nxt  = (w_state_nxt != IDLE);
        w_clk_nxt  = w_run_nxt && (w_cnt_nxt < (w_ne_nxt >> 1));
        w_tick_nxt = w_run_nxt && (w_cnt_nxt == '0);
    end

    // State, counter and clock outputs, all registered so clk_o is glitch-free
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ratio <= CNT_W'(DEF_DIV);
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ratio <= w_ratio_nxt;
            r_clk   <= w_clk_nxt;
            r_tick  <= w_tick_nxt;
            r_busy  <= w_run_nxt;
        end
    end

    // Ratio handshake: one-deep pending register, ready drops while it is occupied
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_pend     <= div_i;
                r_pend_vld <= 1'b1;
                r_ready    <= 1'b0;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
                r_ready    <= 1'b1;
            end
        end
    end

    assign div_ready_o = r_ready;
    assign clk_o       = r_clk;
    assign tick_o      = r_tick;
    assign busy_o      = r_busy;

endmodule
